// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared colour, screen-code and plotter-state definitions
package pacman_pkg;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_BLUE   = 3'b001;

  localparam logic [1:0] SCR_GAME  = 2'd0;
  localparam logic [1:0] SCR_CLEAR = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;
  localparam logic [1:0] SCR_START = 2'd3;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPRITE,
    ST_FILL,
    ST_DONE
  } plot_state_e;

  // Sprite requests use the colour select; fills take their colour from the screen code.
  function automatic logic [2:0] pixel_colour(input logic [1:0] scr, input logic [1:0] col);
    logic [1:0] sel;
    logic [2:0] rgb;
    sel = (scr == SCR_GAME) ? col : scr;
    case (sel)
      2'd1:    rgb = COL_YELLOW;
      2'd2:    rgb = COL_RED;
      2'd3:    rgb = COL_BLUE;
      default: rgb = COL_BLACK;
    endcase
    if (scr == SCR_CLEAR) rgb = COL_BLACK;
    return rgb;
  endfunction

endpackage

// File: rtl/xy_counter.sv
// rtl/xy_counter.sv - 2-D raster counter, x fastest, with next-position lookahead
module xy_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic [XW-1:0] nx_cx,
  output logic [YW-1:0] nx_cy,
  output logic          last
);

  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end = (r_cx == w - XW'(1));
  assign w_y_end = (r_cy == h - YW'(1));
  assign last    = w_x_end && w_y_end;

  // nx_* lets the owner register the following pixel in the same cycle the counter steps.
  assign nx_cx = w_x_end ? '0 : r_cx + XW'(1);
  assign nx_cy = w_x_end ? (w_y_end ? '0 : r_cy + YW'(1)) : r_cy;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (en) begin
      r_cx <= nx_cx;
      r_cy <= nx_cy;
    end
  end

  assign cx = r_cx;
  assign cy = r_cy;

endmodule

// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - streams sprite squares or full-screen fills into the VGA adapter
module sprite_plotter
  import pacman_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  input  logic [1:0] s_plot_color,
  input  logic [1:0] s_screen,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  plot_state_e r_state, w_state_nx;
  logic [7:0]  r_bx;
  logic [6:0]  r_by;
  logic [1:0]  r_col, r_scr;
  logic [7:0]  r_vx;
  logic [6:0]  r_vy;
  logic [2:0]  r_vcol;
  logic        r_vplot, r_busy, r_done;

  logic        w_clr, w_en, w_last, w_lat, w_emit, w_done_nx, w_on;
  logic [7:0]  w_cx, w_nx_cx, w_lim_w, w_bx, w_px;
  logic [6:0]  w_cy, w_nx_cy, w_lim_h, w_by, w_py;
  logic [1:0]  w_col, w_scr;
  logic [8:0]  w_sx;
  logic [7:0]  w_sy;

  assign w_lim_w = (r_state == ST_FILL) ? 8'(SCREEN_W) : 8'(SPRITE_W);
  assign w_lim_h = (r_state == ST_FILL) ? 7'(SCREEN_H) : 7'(SPRITE_H);

  xy_counter #(.XW(8), .YW(7)) u_xy (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .w     (w_lim_w),
    .h     (w_lim_h),
    .cx    (w_cx),
    .cy    (w_cy),
    .nx_cx (w_nx_cx),
    .nx_cy (w_nx_cy),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Outputs are registered, so each edge loads the pixel for the following cycle.
  always_comb begin
    w_state_nx = r_state;
    w_clr      = 1'b0;
    w_en       = 1'b0;
    w_lat      = 1'b0;
    w_emit     = 1'b0;
    w_done_nx  = 1'b0;
    w_bx       = r_bx;
    w_by       = r_by;
    w_px       = w_nx_cx;
    w_py       = w_nx_cy;
    w_col      = r_col;
    w_scr      = r_scr;
    case (r_state)
      ST_IDLE: begin
        if (plot) begin
          w_lat      = 1'b1;
          w_clr      = 1'b1;
          w_emit     = 1'b1;
          w_bx       = x_pos;
          w_by       = y_pos;
          w_px       = '0;
          w_py       = '0;
          w_col      = s_plot_color;
          w_scr      = s_screen;
          w_state_nx = (s_screen == SCR_GAME) ? ST_SPRITE : ST_FILL;
        end
      end
      ST_SPRITE, ST_FILL: begin
        w_en = 1'b1;
        if (w_last) begin
          w_state_nx = ST_DONE;
          w_done_nx  = 1'b1;
        end else begin
          w_emit = 1'b1;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_scr != SCR_GAME) begin
      w_bx = '0;
      w_by = '0;
    end
    w_sx = {1'b0, w_bx} + {1'b0, w_px};
    w_sy = {1'b0, w_by} + {1'b0, w_py};
    w_on = (w_sx < 9'(SCREEN_W)) && (w_sy < 8'(SCREEN_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bx    <= '0;
      r_by    <= '0;
      r_col   <= '0;
      r_scr   <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_vcol  <= COL_BLACK;
      r_vplot <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_lat) begin
        r_bx  <= x_pos;
        r_by  <= y_pos;
        r_col <= s_plot_color;
        r_scr <= s_screen;
      end
      if (w_emit) begin
        r_vx   <= w_sx[7:0];
        r_vy   <= w_sy[6:0];
        r_vcol <= pixel_colour(w_scr, w_col);
      end
      r_vplot <= w_emit && w_on;
      r_busy  <= w_emit;
      r_done  <= w_done_nx;
    end
  end

  assign vga_x      = r_vx;
  assign vga_y      = r_vy;
  assign vga_colour = r_vcol;
  assign vga_plot   = r_vplot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - directed self-checking bench for sprite_plotter
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       reset, plot;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic [1:0] s_plot_color, s_screen;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  int n_vec  = 0;
  int n_miss = 0;
  int pair_strobes;

  always #5 clk = ~clk;

  sprite_plotter dut (
    .clk          (clk),
    .reset        (reset),
    .plot         (plot),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .s_plot_color (s_plot_color),
    .s_screen     (s_screen),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .busy         (busy),
    .done         (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_x"}, vga_x, 0);
    check_val({tag, "_y"}, vga_y, 0);
    check_val({tag, "_col"}, vga_colour, 0);
    check_val({tag, "_plot"}, vga_plot, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
  endtask

  // Presents a request for one edge, then scrambles the inputs.
  task automatic start(input int x, input int y, input int col, input int scr);
    x_pos = 8'(x); y_pos = 7'(y); s_plot_color = 2'(col); s_screen = 2'(scr);
    plot = 1'b1;
    tick;
    plot = 1'b0;
    x_pos = 8'd201; y_pos = 7'd99; s_plot_color = 2'd3; s_screen = 2'd3;
  endtask

  task automatic expect_sprite(input int bx, input int by, input int ecol, input int exp_strobes,
                               input int poke_idx, input bit done_poke, output int strobes);
    int px, py;
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      px = bx + i % 4;
      py = by + i / 4;
      check_val("sp_busy", busy, 1);
      check_val("sp_done", done, 0);
      if (px < 160 && py < 120) begin
        check_val("sp_plot", vga_plot, 1);
        check_val("sp_x", vga_x, px);
        check_val("sp_y", vga_y, py);
        check_val("sp_col", vga_colour, ecol);
      end else begin
        check_val("sp_clip", vga_plot, 0);
      end
      strobes += int'(vga_plot);
      plot = (i == poke_idx);
      s_screen = 2'd2;
      tick;
    end
    plot = done_poke;
    check_val("sp_done_pulse", done, 1);
    check_val("sp_done_busy", busy, 0);
    check_val("sp_done_plot", vga_plot, 0);
    tick;
    plot = 1'b0;
    check_val("sp_strobes", strobes, exp_strobes);
    check_val("sp_idle_busy", busy, 0);
    check_val("sp_idle_done", done, 0);
  endtask

  initial begin
    int st, bad, fx0, fy0, fxl, fyl, cnt;
    reset = 1'b1; plot = 1'b0;
    x_pos = '0; y_pos = '0; s_plot_color = '0; s_screen = '0;
    tick; tick;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick;
    check_reset_outputs("idle");

    // Basic yellow sprite.
    start(10, 20, 1, 0);
    expect_sprite(10, 20, 6, 16, -1, 1'b0, st);

    // Corner sprite clipped to a 2x2 visible region.
    start(158, 118, 2, 0);
    expect_sprite(158, 118, 4, 4, -1, 1'b0, st);

    // Game-over fill; x/y inputs must be ignored.
    start(77, 33, 1, 2);
    bad = 0; cnt = 0; fx0 = -1; fy0 = -1; fxl = -1; fyl = -1;
    for (int i = 0; i < 19200; i++) begin
      if (i == 0) begin fx0 = vga_x; fy0 = vga_y; end
      if (i == 19199) begin fxl = vga_x; fyl = vga_y; end
      cnt += int'(vga_plot);
      if (!(vga_plot && busy && !done && vga_colour == 3'b100 &&
            vga_x == 8'(i % 160) && vga_y == 7'(i / 160))) bad++;
      tick;
    end
    check_val("fill_bad_pixels", bad, 0);
    check_val("fill_strobes", cnt, 19200);
    check_val("fill_first_x", fx0, 0);
    check_val("fill_first_y", fy0, 0);
    check_val("fill_last_x", fxl, 159);
    check_val("fill_last_y", fyl, 119);
    check_val("fill_done", done, 1);
    check_val("fill_done_busy", busy, 0);
    tick;
    check_val("fill_idle_done", done, 0);

    // Plot pulsed mid-sprite and in the DONE cycle is ignored; the next cycle is accepted.
    start(30, 40, 3, 0);
    expect_sprite(30, 40, 1, 16, 5, 1'b1, st);
    start(50, 60, 2, 0);
    expect_sprite(50, 60, 4, 16, -1, 1'b0, st);

    // Reset at pixel 8 abandons the frame.
    start(70, 80, 1, 0);
    for (int i = 0; i < 8; i++) tick;
    check_val("rmid_x", vga_x, 70);
    check_val("rmid_y", vga_y, 82);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_outputs("rmid");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cnt += int'(done) + int'(busy) + int'(vga_plot);
      tick;
    end
    check_val("rmid_quiet", cnt, 0);
    start(100, 50, 3, 0);
    expect_sprite(100, 50, 1, 16, -1, 1'b0, st);

    // Back-to-back erase then draw on the cycle after done.
    start(5, 5, 0, 0);
    expect_sprite(5, 5, 0, 16, -1, 1'b0, st);
    pair_strobes = st;
    start(6, 5, 1, 0);
    expect_sprite(6, 5, 6, 16, -1, 1'b0, st);
    pair_strobes += st;
    check_val("b2b_strobes", pair_strobes, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Pixel-writing stage directly downstream of the game `controller`. On each `plot` request it latches the controller's position, colour select and screen select. It then streams pixels into the VGA adapter, one per clock: either a solid sprite square at the latched position, or a full-screen raster fill for the start, clear and game-over screens. `done` tells the controller the frame update is complete.

## Interface
- `SPRITE_W`, default 4: sprite width in pixels.
- `SPRITE_H`, default 4: sprite height in pixels.
- `SCREEN_W`, default 160: visible width.
- `SCREEN_H`, default 120: visible height.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `plot`  in  1  draw request, sampled only in IDLE.
- `x_pos`  in  8  sprite top-left column.
- `y_pos`  in  7  sprite top-left row.
- `s_plot_color`  in  2  sprite colour: 0 black/erase, 1 yellow (pacman), 2 red (ghost), 3 blue (wall).
- `s_screen`  in  2  request type: 0 sprite, 1 clear black, 2 game-over red fill, 3 start-screen blue fill.
- `vga_x`  out  8  pixel column.
- `vga_y`  out  7  pixel row.
- `vga_colour`  out  3  RGB.
- `vga_plot`  out  1  pixel write strobe.
- `busy`  out  1  high from acceptance through the last pixel.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
- States: IDLE, SPRITE, FILL, DONE.
- IDLE with `plot`=1:
  - latch `x_pos`, `y_pos`, colour and `s_screen`; clear counters cx=cy=0.
  - go to SPRITE if `s_screen`=0, else FILL.
- Colour map (3-bit RGB): black 000, yellow 110, red 100, blue 001.
  - Fill colours: screen 1 is black, 2 is red, 3 is blue.
- SPRITE:
  - each cycle emit `vga_x`=bx+cx and `vga_y`=by+cy, using 9-bit/8-bit sums with no wrap.
  - `vga_plot`=1 only if the sum is below `SCREEN_W`/`SCREEN_H`. Off-screen pixels are clipped: strobe low, but the cycle is still consumed.
  - cx increments to `SPRITE_W`-1, then wraps to 0 and cy increments.
  - after cx=`SPRITE_W`-1 and cy=`SPRITE_H`-1, go to DONE.
- FILL: same raster (x fastest) over 0..`SCREEN_W`-1 × 0..`SCREEN_H`-1, with `vga_plot`=1 every cycle.
- DONE: `done`=1, `busy`=0, `vga_plot`=0; next state IDLE.
- `plot` outside IDLE is ignored, with no queueing. The controller must wait for `done`.
- `plot` arriving in the DONE cycle is also ignored.
- Inputs changing after acceptance have no effect on the current operation.

## Timing
- All outputs are registered.
- Reset values: `vga_x`=0, `vga_y`=0, `vga_colour`=000, `vga_plot`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- `plot` sampled at edge k:
  - `busy`=1 from cycle k+1.
  - first pixel is valid in cycle k+1.
  - sprite: last pixel in cycle k+`SPRITE_W`·`SPRITE_H` (k+16 by default), `done` at k+17.
  - fill: last pixel in cycle k+19200, `done` at k+19201.
- `busy` and `vga_plot` are never high together with `done`.
- Minimum spacing between accepted requests is N+2 cycles, where N is the pixel count.
- `reset` mid-operation: the next edge forces IDLE and the reset values, and the partial frame is abandoned. No `done` is emitted.

## Structure
- Shared package `pacman_pkg`:
  - colour constants (`COL_BLACK`, `COL_YELLOW`, `COL_RED`, `COL_BLUE`).
  - screen codes (`SCR_GAME`, `SCR_CLEAR`, `SCR_OVER`, `SCR_START`).
  - `SCREEN_W`/`SCREEN_H` defaults.
  - the plotter state enum.
- One sub-module, `xy_counter`:
  - parameterised 2-D raster counter with `clr`, `en`, limits `w`/`h`, outputs `cx`/`cy` and `last`.
  - used for both SPRITE and FILL, with limits muxed by state.

## Test plan
- Reset, then `plot` with s_screen=0, x=10, y=20, colour 1: 16 strobes over (10..13, 20..23), x fastest, colour 110. `done` 17 cycles after acceptance; `busy` high for exactly 16 cycles.
- Sprite at x=158, y=118, colour 2: 16 cycles consumed. `vga_plot` high only for (158..159, 118..119), i.e. 4 strobes, colour 100.
- `plot` with s_screen=2: 19200 strobes of colour 100 with first (0,0) and last (159,119), then `done`.
- `plot` pulsed mid-sprite and again in the DONE cycle: both ignored, with no second operation. A `plot` one cycle after DONE is accepted.
- `reset` asserted at pixel 8 of a sprite: the next cycle shows all outputs at reset values and no `done`. A fresh `plot` then completes normally.
- Back-to-back sprites: erase (colour 0) at (5,5), then draw (colour 1) at (6,5) issued on the cycle after `done`. This yields 32 strobes with colours 000 then 110.
